// File: rtl/ahb_apb_ctrl.sv
// AHB-Lite to APB bridge: three 64 MB APB slots from 0x8000_0000, one APB access per AHB transfer.
// Define ERROR_RESP_EN to answer out-of-range transfers with a two-cycle ERROR response.
module ahb_apb_ctrl (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic        HREADYin,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic        HREADYout,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA,
   input  logic [31:0] PRDATA,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic        PWRITE,
   output logic [2:0]  PSELx,
   output logic        PENABLE
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_RENABLE,
      ST_WWAIT,
      ST_WRITE,
      ST_WENABLE
`ifdef ERROR_RESP_EN
      ,
      ST_ERR1,
      ST_ERR2
`endif
   } state_t;

   typedef struct packed {
      logic       psel_en;
      logic       penable;
      logic       hready;
      logic [1:0] hresp;
   } outs_t;

   state_t      state, state_nxt;
   outs_t       outs;
   logic [2:0]  sel_dec, sel_r;
   logic [31:0] addr_r, pwdata_r;
   logic        write_r;
   logic        active, valid;

   // Output values that hold for the whole time the FSM sits in state s.
   function automatic outs_t outs_for(input state_t s);
      outs_t o;
      o = '{psel_en: 1'b0, penable: 1'b0, hready: 1'b1, hresp: 2'b00};
      case (s)
         ST_READ, ST_WRITE: begin
            o.psel_en = 1'b1;
            o.hready  = 1'b0;
         end
         ST_RENABLE, ST_WENABLE: begin
            o.psel_en = 1'b1;
            o.penable = 1'b1;
         end
         ST_WWAIT: o.hready = 1'b0;
`ifdef ERROR_RESP_EN
         ST_ERR1: begin
            o.hready = 1'b0;
            o.hresp  = 2'b01;
         end
         ST_ERR2: o.hresp = 2'b01;
`endif
         default: ;
      endcase
      return o;
   endfunction

   always_comb begin
      // NOTE: assign a default before the case so every path drives sel_dec and no latch is inferred.
      sel_dec = 3'b000;
      case (HADDR[31:26])
         6'b100000: sel_dec = 3'b001;
         6'b100001: sel_dec = 3'b010;
         6'b100010: sel_dec = 3'b100;
         default:   sel_dec = 3'b000;
      endcase
   end

   assign active = HREADYin && (HTRANS == 2'b10 || HTRANS == 2'b11);
   assign valid  = active && (sel_dec != 3'b000);

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_READ:  state_nxt = ST_RENABLE;
         ST_WWAIT: state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = ST_WENABLE;
`ifdef ERROR_RESP_EN
         ST_ERR1:  state_nxt = ST_ERR2;
`endif
         default: begin
            // Decision states: IDLE, RENABLE, WENABLE (and ERR2) all accept the next transfer.
            if (valid)
               state_nxt = HWRITE ? ST_WWAIT : ST_READ;
`ifdef ERROR_RESP_EN
            else if (active)
               state_nxt = ST_ERR1;
`endif
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state    <= ST_IDLE;
         outs     <= outs_for(ST_IDLE);
         sel_r    <= 3'b000;
         addr_r   <= 32'h0;
         write_r  <= 1'b0;
         pwdata_r <= 32'h0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values, whatever the statement order.
         state <= state_nxt;
         outs  <= outs_for(state_nxt);
         if (HREADYout && valid) begin
            addr_r  <= HADDR;
            write_r <= HWRITE;
            sel_r   <= sel_dec;
         end
         if (state == ST_WWAIT)
            pwdata_r <= HWDATA;
      end
   end

   assign HREADYout = outs.hready;
   assign HRESP     = outs.hresp;
   assign PENABLE   = outs.penable;
   assign PSELx     = outs.psel_en ? sel_r : 3'b000;
   assign PADDR     = addr_r;
   assign PWDATA    = pwdata_r;
   assign PWRITE    = write_r;
   // Read data passes straight through during the enable cycle only.
   assign HRDATA    = (state == ST_RENABLE) ? PRDATA : 32'h0;

endmodule

// File: tb/tb_ahb_apb_ctrl.sv
// Self-checking bench for ahb_apb_ctrl: a per-transfer cycle-pattern model checked every cycle,
// plus directed literal checks. Honours ERROR_RESP_EN the same way as the design.
module tb_ahb_apb_ctrl;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic        HCLK, HRESET, HWRITE, HREADYin;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR, HWDATA, PRDATA;
   logic        HREADYout, PWRITE, PENABLE;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA, PADDR, PWDATA;
   logic [2:0]  PSELx;

   int checks = 0;
   int errors = 0;

   ahb_apb_ctrl dut (
      .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HREADYin(HREADYin), .HADDR(HADDR), .HWDATA(HWDATA),
      .HREADYout(HREADYout), .HRESP(HRESP), .HRDATA(HRDATA), .PRDATA(PRDATA),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx), .PENABLE(PENABLE)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One expected bus cycle: what the APB/AHB outputs must show for that cycle.
   typedef struct packed {
      logic [2:0] psel;
      logic       pen;
      logic       rdy;
      logic [1:0] resp;
      logic       rd;
      logic       cap;
   } cyc_t;

   function automatic cyc_t mk(input logic [2:0] psel, input logic pen, input logic rdy,
                               input logic err, input logic rd, input logic cap);
      cyc_t c;
      c.psel = psel;
      c.pen  = pen;
      c.rdy  = rdy;
      c.resp = err ? 2'b01 : 2'b00;
      c.rd   = rd;
      c.cap  = cap;
      return c;
   endfunction

   cyc_t        q[$];
   cyc_t        cur;
   logic [31:0] m_paddr, m_pwdata;
   logic        m_pwrite;
   logic [2:0]  sel;
   bit          model_live = 1'b0;

   // Each accepted transfer appends the cycles it must occupy; an empty queue means an idle bus.
   always @(posedge HCLK) begin
      if (HRESET) begin
         q.delete();
         cur        = mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         m_paddr    = 32'h0;
         m_pwdata   = 32'h0;
         m_pwrite   = 1'b0;
         model_live = 1'b1;
      end else if (model_live) begin
         if (cur.cap) m_pwdata = HWDATA;
         if (cur.rdy && HREADYin && HTRANS[1]) begin
            if (HADDR >= 32'h8000_0000 && HADDR < 32'h8C00_0000) begin
               sel      = 3'(3'b001 << ((HADDR - 32'h8000_0000) >> 26));
               m_paddr  = HADDR;
               m_pwrite = HWRITE;
               if (HWRITE) begin
                  q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
                  q.push_back(mk(sel,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                  q.push_back(mk(sel,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
               end else begin
                  q.push_back(mk(sel,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                  q.push_back(mk(sel,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
               end
            end
`ifdef ERROR_RESP_EN
            else begin
               q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
               q.push_back(mk(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
            end
`endif
         end
         cur = (q.size() > 0) ? q.pop_front() : mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
   end

   always @(negedge HCLK) begin
      if (model_live) begin
         check("m_hreadyout", 32'(HREADYout), 32'(cur.rdy));
         check("m_hresp",     32'(HRESP),     32'(cur.resp));
         check("m_hrdata",    HRDATA,         cur.rd ? PRDATA : 32'h0);
         check("m_psel",      32'(PSELx),     32'(cur.psel));
         check("m_penable",   32'(PENABLE),   32'(cur.pen));
         check("m_paddr",     PADDR,          m_paddr);
         check("m_pwdata",    PWDATA,         m_pwdata);
         check("m_pwrite",    32'(PWRITE),    32'(m_pwrite));
      end
   end

   // Present inputs for the coming cycle, shortly after the active edge.
   task automatic drive(input logic rst, input logic rdy, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
      @(posedge HCLK);
      #2;
      HRESET = rst; HREADYin = rdy; HTRANS = tr; HWRITE = wr;
      HADDR = a; HWDATA = wd; PRDATA = rd;
   endtask

   task automatic idle(input logic [31:0] rd);
      drive(1'b0, 1'b1, T_IDLE, 1'b0, 32'h0, 32'h0, rd);
   endtask

   initial begin
      HRESET = 1'b1; HREADYin = 1'b1; HTRANS = T_IDLE; HWRITE = 1'b0;
      HADDR = 32'h0; HWDATA = 32'h0; PRDATA = 32'h0;
      repeat (2) @(posedge HCLK);
      idle(32'h0);
      @(negedge HCLK);
      check("rst_hready", 32'(HREADYout), 32'd1);
      check("rst_psel",   32'(PSELx),     32'd0);
      check("rst_pen",    32'(PENABLE),   32'd0);
      check("rst_paddr",  PADDR,          32'h0);
      check("rst_pwdata", PWDATA,         32'h0);
      check("rst_hresp",  32'(HRESP),     32'd0);
      check("rst_hrdata", HRDATA,         32'h0);

      // Single write: two wait states, PSEL for two cycles
      drive(1'b0, 1'b1, T_NONSEQ, 1'b1, 32'h8000_0010, 32'h0, 32'h0);
      drive(1'b0, 1'b1, T_IDLE, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0);
      @(negedge HCLK);
      check("wr_wait_rdy",  32'(HREADYout), 32'd0);
      check("wr_wait_psel", 32'(PSELx),     32'd0);
      idle(32'h0);
      @(negedge HCLK);
      check("wr_setup_psel",  32'(PSELx),   32'b001);
      check("wr_setup_pen",   32'(PENABLE), 32'd0);
      check("wr_setup_rdy",   32'(HREADYout), 32'd0);
      check("wr_setup_pwdata", PWDATA,      32'hDEAD_BEEF);
      check("wr_setup_paddr",  PADDR,       32'h8000_0010);
      idle(32'h0);
      @(negedge HCLK);
      check("wr_en_psel", 32'(PSELx),     32'b001);
      check("wr_en_pen",  32'(PENABLE),   32'd1);
      check("wr_en_rdy",  32'(HREADYout), 32'd1);
      idle(32'h0);
      @(negedge HCLK);
      check("wr_done_psel", 32'(PSELx), 32'd0);

      // Single read: one wait state, data passes through in enable cycle
      drive(1'b0, 1'b1, T_NONSEQ, 1'b0, 32'h8400_0004, 32'h0, 32'h0);
      idle(32'h1234_5678);
      @(negedge HCLK);
      check("rd_setup_psel",   32'(PSELx),     32'b010);
      check("rd_setup_rdy",    32'(HREADYout), 32'd0);
      check("rd_setup_hrdata", HRDATA,         32'h0);
      idle(32'h1234_5678);
      @(negedge HCLK);
      check("rd_en_pen",    32'(PENABLE),   32'd1);
      check("rd_en_rdy",    32'(HREADYout), 32'd1);
      check("rd_en_hrdata", HRDATA,         32'h1234_5678);
      idle(32'h1234_5678);
      @(negedge HCLK);
      check("rd_done_hrdata", HRDATA, 32'h0);

      // Write then read back-to-back on slot 2, next address held during the wait states
      drive(1'b0, 1'b1, T_NONSEQ, 1'b1, 32'h8800_0000, 32'h0, 32'h0);
      drive(1'b0, 1'b1, T_NONSEQ, 1'b0, 32'h8800_0004, 32'hA5A5_0001, 32'h0);
      drive(1'b0, 1'b1, T_NONSEQ, 1'b0, 32'h8800_0004, 32'h0, 32'h0);
      @(negedge HCLK);
      check("b2b_1_psel", 32'(PSELx), 32'b100);
      check("b2b_1_pen",  32'(PENABLE), 32'd0);
      drive(1'b0, 1'b1, T_NONSEQ, 1'b0, 32'h8800_0004, 32'h0, 32'h0);
      @(negedge HCLK);
      check("b2b_2_psel", 32'(PSELx), 32'b100);
      check("b2b_2_pen",  32'(PENABLE), 32'd1);
      idle(32'hCAFE_F00D);
      @(negedge HCLK);
      check("b2b_3_psel",  32'(PSELx), 32'b100);
      check("b2b_3_pen",   32'(PENABLE), 32'd0);
      check("b2b_3_paddr", PADDR, 32'h8800_0004);
      idle(32'hCAFE_F00D);
      @(negedge HCLK);
      check("b2b_4_psel",   32'(PSELx), 32'b100);
      check("b2b_4_pen",    32'(PENABLE), 32'd1);
      check("b2b_4_hrdata", HRDATA, 32'hCAFE_F00D);
      idle(32'h0);

      // SEQ write at the top word of the last slot
      drive(1'b0, 1'b1, T_SEQ, 1'b1, 32'h8BFF_FFFC, 32'h0, 32'h0);
      drive(1'b0, 1'b1, T_IDLE, 1'b0, 32'h0, 32'h0BAD_F00D, 32'h0);
      idle(32'h0);
      @(negedge HCLK);
      check("top_psel", 32'(PSELx), 32'b100);
      idle(32'h0);
      idle(32'h0);

      // Reset pulsed during the write setup cycle aborts the access
      drive(1'b0, 1'b1, T_NONSEQ, 1'b1, 32'h8000_0020, 32'h0, 32'h0);
      drive(1'b0, 1'b1, T_IDLE, 1'b0, 32'h0, 32'h1111_2222, 32'h0);
      drive(1'b1, 1'b1, T_IDLE, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge HCLK);
      check("rstw_setup_psel", 32'(PSELx), 32'b001);
      idle(32'h0);
      @(negedge HCLK);
      check("rstw_psel", 32'(PSELx),     32'd0);
      check("rstw_pen",  32'(PENABLE),   32'd0);
      check("rstw_rdy",  32'(HREADYout), 32'd1);
      idle(32'h0);
      @(negedge HCLK);
      check("rstw_noen", 32'(PENABLE), 32'd0);

      // Out-of-range read, then out-of-range write just past the last slot
      drive(1'b0, 1'b1, T_NONSEQ, 1'b0, 32'h9000_0000, 32'h0, 32'h5555_5555);
      idle(32'h5555_5555);
      @(negedge HCLK);
      check("oor_psel", 32'(PSELx), 32'd0);
`ifdef ERROR_RESP_EN
      check("oor_e1_rdy",  32'(HREADYout), 32'd0);
      check("oor_e1_resp", 32'(HRESP),     32'b01);
`else
      check("oor_rdy",    32'(HREADYout), 32'd1);
      check("oor_resp",   32'(HRESP),     32'b00);
      check("oor_hrdata", HRDATA,         32'h0);
`endif
      idle(32'h0);
      @(negedge HCLK);
`ifdef ERROR_RESP_EN
      check("oor_e2_rdy",  32'(HREADYout), 32'd1);
      check("oor_e2_resp", 32'(HRESP),     32'b01);
`else
      check("oor_after_resp", 32'(HRESP), 32'b00);
`endif
      drive(1'b0, 1'b1, T_NONSEQ, 1'b1, 32'h8C00_0000, 32'h0, 32'h0);
      drive(1'b0, 1'b1, T_IDLE, 1'b0, 32'h0, 32'hFFFF_0000, 32'h0);
      idle(32'h0);
      idle(32'h0);
      @(negedge HCLK);
      check("oorw_pwdata", PWDATA, 32'h0);

      // BUSY and HREADYin low never start an access
      drive(1'b0, 1'b1, T_BUSY, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
      idle(32'h0);
      @(negedge HCLK);
      check("busy_psel", 32'(PSELx),     32'd0);
      check("busy_rdy",  32'(HREADYout), 32'd1);
      drive(1'b0, 1'b0, T_NONSEQ, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
      idle(32'h0);
      @(negedge HCLK);
      check("nrdy_psel", 32'(PSELx),   32'd0);
      check("nrdy_pen",  32'(PENABLE), 32'd0);
      idle(32'h0);
      idle(32'h0);
      @(negedge HCLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
